branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Tracks every in-flight branch in program order, from dispatch until it is resolved by the execute stage.
- Produces the commit-side and mispredict-side branch signals for the branch position tracker: cmt_brch/cmt_brch_indx and mis_pred/brch_mis_indx.
- Sits between dispatch (4-wide, ROB index nxt_indx) and branch execute.
- Retires branches strictly oldest-first.

Parameters:
DEPTH, 8, number of outstanding-branch queue entries (power of 2, >= 4)
IDXW, 6, ROB index width
FLUSH_CYC, 2, cycles the block stays in FLUSH after a mispredict pulse (>= 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
brch_vld  in  4  bit k set: dispatch slot k is a branch this cycle
nxt_indx  in  IDXW  ROB index of slot 0; slot k index = nxt_indx+k mod 2^IDXW
res_vld  in  1  execute resolved a branch this cycle
res_indx  in  IDXW  ROB index of the resolved branch
res_mispred  in  1  resolved branch was mispredicted
full  out  1  combinational; count > DEPTH-4; dispatch must not present branches
cmt_brch  out  1  registered 1-cycle pulse; oldest branch retired correctly predicted
cmt_brch_indx  out  IDXW  index of the retired branch; valid with cmt_brch
mis_pred  out  1  registered 1-cycle pulse; oldest unretired branch mispredicted
brch_mis_indx  out  IDXW  index of the mispredicted branch; valid with mis_pred
ovf  out  1  sticky; an allocation was dropped

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. Reset empties the queue (count=0, head=tail=0) and puts the FSM in RUN. cmt_brch, mis_pred and ovf reset to 0; cmt_brch_indx and brch_mis_indx reset to 0.
- Queue entry fields: {vld, indx[IDXW], done, bad}. Circular buffer with head/tail pointers of log2(DEPTH) bits that wrap naturally, plus count of log2(DEPTH)+1 bits.
- Allocation (RUN only): set bits of brch_vld are enqueued in slot order 0..3 and compacted contiguously at tail. Each new entry gets indx = nxt_indx+k truncated to IDXW, with done=bad=0. tail advances and count increases by popcount(brch_vld).
- Allocation overflow: if count+popcount exceeds DEPTH, the whole group is dropped, ovf is set, and queue state is unchanged.
- Resolution (RUN only): res_vld compares res_indx against all valid entries, without regard to done.
  - First match from head sets done=1 and bad=res_mispred.
  - No match: ignored.
  - Match on an entry already done: ignored, with no change to bad.
- Retire (RUN), evaluated on registered entry state:
  - Head vld, done, !bad: next edge pulses cmt_brch with cmt_brch_indx=head.indx, pops the head, advances head and decrements count.
  - Head vld, done, bad: next edge pulses mis_pred with brch_mis_indx=head.indx, clears all entries, sets count=0, head=tail=0, and enters FLUSH. cmt_brch is NOT asserted for that branch.
  - At most one retire per cycle.
- Latency: res_vld on the head at edge N makes cmt_brch or mis_pred high during cycle N+1 (one cycle after done is registered).
- Simultaneous events:
  - Alloc and pop in the same cycle: both apply; count = count + n - 1.
  - Resolution of a just-allocated entry in its own allocation cycle: not matched.
  - Mispredict retire and alloc in the same cycle: the alloc is discarded.
- FSM states:
  - RUN -> FLUSH on mispredict retire.
  - FLUSH: load a counter with FLUSH_CYC-1 and decrement it each cycle. brch_vld and res_vld are ignored, and full=1.
  - FLUSH -> RUN when the counter reaches 0.
- Reset mid-FLUSH returns to RUN with the queue empty.
- Index compare is an exact IDXW-bit equality; ROB wrap is handled by modulo arithmetic.

Decomposition:
- Shared package: IDXW, the ROB size constant, and the entry struct typedef {vld, indx, done, bad}. The branch position tracker reuses these.
- One natural sub-module, brq_cam: parallel res_indx match with a first-from-head priority select that returns the entry number. The top level holds the pointers, FSM and output registers.

Test Plan:
- Reset, then brch_vld=4'b0101 with nxt_indx=62 -> entries hold 62 and 0 (wrap); count=2; no pulses.
- Resolve index 0 (younger) correct, then 62 correct -> cmt_brch for 62 one cycle after the second resolve, then cmt_brch for 0 the next cycle.
- Entries 10,11,13 queued; resolve 11 with res_mispred=1 -> nothing until 10 resolves correct -> cmt 10, then mis_pred with brch_mis_indx=11. Queue empty; alloc/res ignored for 2 cycles; full=1 during FLUSH.
- count=5 with DEPTH=8 -> full=1. Present 4 branches anyway -> group dropped and ovf=1 (sticky through the next reset).
- res_indx=40 not queued, and a duplicate resolve of a done entry -> no state change, no pulses.
- Assert rst_n low during FLUSH -> outputs are 0 immediately; after release, an alloc works in the first cycle.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-queue types: ROB sizing and the outstanding-branch entry layout.
package branch_resolve_unit_pkg;

  localparam int unsigned ROB_SIZE = 64;
  localparam int unsigned BRQ_IDXW = $clog2(ROB_SIZE);

  typedef struct packed {
    logic                vld;
    logic [BRQ_IDXW-1:0] indx;
    logic                done;
    logic                bad;
  } brq_entry_t;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cam.sv
// Parallel ROB-index match over the branch queue; returns the first hit walking from head.
module brq_cam
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  brq_entry_t [DEPTH-1:0] ents,
  input  logic [PW-1:0]          head,
  input  logic [BRQ_IDXW-1:0]    key,
  output logic                   hit,
  output logic [PW-1:0]          hit_slot
);

  logic [DEPTH-1:0] match;
  logic [PW-1:0]    slot;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = ents[i].vld && (ents[i].indx == key);
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_slot = head;
    slot     = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (!hit && match[slot]) begin
        hit      = 1'b1;
        hit_slot = slot;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// In-order branch queue: allocates at dispatch, marks resolution, retires oldest-first
// as commit or mispredict pulses, and flushes for FLUSH_CYC cycles after a mispredict.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned IDXW      = BRQ_IDXW,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      brch_vld,
  input  logic [IDXW-1:0] nxt_indx,
  input  logic            res_vld,
  input  logic [IDXW-1:0] res_indx,
  input  logic            res_mispred,
  output logic            full,
  output logic            cmt_brch,
  output logic [IDXW-1:0] cmt_brch_indx,
  output logic            mis_pred,
  output logic [IDXW-1:0] brch_mis_indx,
  output logic            ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                  state;
  logic [FW-1:0]           fcnt;
  brq_entry_t [DEPTH-1:0]  ents, ents_n;
  logic [PW-1:0]           head, tail, head_n, tail_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [2:0]              n_alloc;
  logic                    hit;
  logic [PW-1:0]           hit_slot;
  brq_entry_t              head_ent;
  logic                    pop_ok, pop_bad, alloc_ok, ovf_set;
  logic [PW-1:0]           slot;
  logic [2:0]              off;

  brq_cam #(.DEPTH(DEPTH)) u_cam (
    .ents     (ents),
    .head     (head),
    .key      (res_indx),
    .hit      (hit),
    .hit_slot (hit_slot)
  );

  assign n_alloc  = popcnt4(brch_vld);
  assign head_ent = ents[head];
  assign pop_ok   = (state == RUN) && head_ent.vld && head_ent.done && !head_ent.bad;
  assign pop_bad  = (state == RUN) && head_ent.vld && head_ent.done && head_ent.bad;
  assign full     = (state == FLUSH) || (cnt > CW'(DEPTH - 4));

  always_comb begin
    ents_n   = ents;
    head_n   = head;
    tail_n   = tail;
    cnt_n    = cnt;
    alloc_ok = 1'b0;
    ovf_set  = 1'b0;
    slot     = tail;
    off      = '0;
    if (state == RUN) begin
      // Only the first match from head counts; a match on an already-done entry is dropped.
      if (res_vld && hit && !ents[hit_slot].done) begin
        ents_n[hit_slot].done = 1'b1;
        ents_n[hit_slot].bad  = res_mispred;
      end
      if (pop_ok) begin
        ents_n[head] = '0;
        head_n       = head + PW'(1);
      end
      if (n_alloc != 3'd0) begin
        if ((32'(cnt) + 32'(n_alloc)) > DEPTH) begin
          ovf_set = !pop_bad;
        end else begin
          alloc_ok = 1'b1;
          for (int unsigned k = 0; k < 4; k++) begin
            if (brch_vld[k]) begin
              slot              = tail + PW'(off);
              ents_n[slot].vld  = 1'b1;
              ents_n[slot].indx = nxt_indx + IDXW'(k);
              ents_n[slot].done = 1'b0;
              ents_n[slot].bad  = 1'b0;
              off               = off + 3'd1;
            end
          end
          tail_n = tail + PW'(n_alloc);
        end
      end
      cnt_n = cnt + (alloc_ok ? CW'(n_alloc) : '0) - CW'(pop_ok);
      if (pop_bad) begin
        ents_n = '0;
        head_n = '0;
        tail_n = '0;
        cnt_n  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      fcnt          <= '0;
      ents          <= '0;
      head          <= '0;
      tail          <= '0;
      cnt           <= '0;
      cmt_brch      <= 1'b0;
      cmt_brch_indx <= '0;
      mis_pred      <= 1'b0;
      brch_mis_indx <= '0;
      ovf           <= 1'b0;
    end else begin
      ents     <= ents_n;
      head     <= head_n;
      tail     <= tail_n;
      cnt      <= cnt_n;
      cmt_brch <= pop_ok;
      mis_pred <= pop_bad;
      if (pop_ok)  cmt_brch_indx <= head_ent.indx;
      if (pop_bad) brch_mis_indx <= head_ent.indx;
      if (ovf_set) ovf <= 1'b1;
      case (state)
        RUN: begin
          if (pop_bad) begin
            state <= FLUSH;
            fcnt  <= FW'(FLUSH_CYC - 1);
          end
        end
        FLUSH: begin
          if (fcnt == '0) state <= RUN;
          else            fcnt  <= fcnt - FW'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a pulse scoreboard checked by a negedge monitor.
module tb_branch_resolve_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] brch_vld;
  logic [5:0] nxt_indx;
  logic       res_vld;
  logic [5:0] res_indx;
  logic       res_mispred;
  logic       full;
  logic       cmt_brch;
  logic [5:0] cmt_brch_indx;
  logic       mis_pred;
  logic [5:0] brch_mis_indx;
  logic       ovf;

  typedef struct {
    bit         mis;
    logic [5:0] indx;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(8), .IDXW(6), .FLUSH_CYC(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .brch_vld      (brch_vld),
    .nxt_indx      (nxt_indx),
    .res_vld       (res_vld),
    .res_indx      (res_indx),
    .res_mispred   (res_mispred),
    .full          (full),
    .cmt_brch      (cmt_brch),
    .cmt_brch_indx (cmt_brch_indx),
    .mis_pred      (mis_pred),
    .brch_mis_indx (brch_mis_indx),
    .ovf           (ovf)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic exp_cmt(input logic [5:0] i);
    sb.push_back('{mis: 1'b0, indx: i});
  endtask

  task automatic exp_mis(input logic [5:0] i);
    sb.push_back('{mis: 1'b1, indx: i});
  endtask

  task automatic resolve(input logic [5:0] i, input logic bad);
    res_vld     = 1'b1;
    res_indx    = i;
    res_mispred = bad;
    step();
    res_vld     = 1'b0;
    res_mispred = 1'b0;
  endtask

  task automatic alloc(input logic [3:0] v, input logic [5:0] base);
    brch_vld = v;
    nxt_indx = base;
    step();
    brch_vld = 4'b0000;
  endtask

  always @(negedge clk) begin
    if (rst_n && (cmt_brch || mis_pred)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'b0, cmt_brch, mis_pred}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", {30'b0, cmt_brch, mis_pred}, mon_e.mis ? 32'd1 : 32'd2);
        chk("pulse_indx", mon_e.mis ? 32'(brch_mis_indx) : 32'(cmt_brch_indx), 32'(mon_e.indx));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected $finish before it");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; brch_vld = '0; nxt_indx = '0;
    res_vld = 1'b0; res_indx = '0; res_mispred = 1'b0;
    #12;
    chk("rst_cmt", cmt_brch, 0);
    chk("rst_mis", mis_pred, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_full", full, 0);
    chk("rst_cmt_indx", cmt_brch_indx, 0);
    chk("rst_mis_indx", brch_mis_indx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Slots 0 and 2 from base 62: indices 62 and 0 (wrap)
    alloc(4'b0101, 6'd62);
    step();
    chk("full_cnt2", full, 0);
    chk("no_pulse_idle", cmt_brch, 0);
    resolve(6'd0, 1'b0);
    exp_cmt(6'd62);
    exp_cmt(6'd0);
    resolve(6'd62, 1'b0);
    chk("cmt_not_early", cmt_brch, 0);
    step();
    chk("cmt_latency", cmt_brch, 1);
    chk("cmt_latency_indx", cmt_brch_indx, 62);
    step();
    chk("cmt_second", cmt_brch, 1);
    chk("cmt_second_indx", cmt_brch_indx, 0);
    step();

    // 10,11,13 queued; 11 mispredicts but waits behind 10
    alloc(4'b1011, 6'd10);
    resolve(6'd11, 1'b1);
    idle(3);
    exp_cmt(6'd10);
    exp_mis(6'd11);
    resolve(6'd10, 1'b0);
    step();
    step();
    chk("mis_pulse", mis_pred, 1);
    chk("mis_pulse_no_cmt", cmt_brch, 0);
    chk("full_flush1", full, 1);
    brch_vld = 4'b1111; nxt_indx = 6'd20;
    res_vld = 1'b1; res_indx = 6'd13;
    step();
    chk("full_flush2", full, 1);
    chk("mis_one_cycle", mis_pred, 0);
    step();
    brch_vld = '0; res_vld = 1'b0;
    chk("full_after_flush", full, 0);
    alloc(4'b0001, 6'd30);
    exp_cmt(6'd30);
    resolve(6'd30, 1'b0);
    idle(2);

    // Fill toward the full threshold and overflow
    alloc(4'b1111, 6'd0);
    chk("full_cnt4", full, 0);
    alloc(4'b0001, 6'd4);
    chk("full_cnt5", full, 1);
    chk("ovf_before", ovf, 0);
    alloc(4'b1111, 6'd8);
    chk("ovf_set", ovf, 1);
    chk("full_after_drop", full, 1);
    alloc(4'b0111, 6'd5);
    for (int unsigned i = 0; i < 8; i++) begin
      exp_cmt(6'(i));
      resolve(6'(i), 1'b0);
    end
    idle(3);
    chk("full_drained", full, 0);

    // Unmatched and duplicate resolves change nothing
    alloc(4'b0011, 6'd50);
    resolve(6'd51, 1'b0);
    resolve(6'd51, 1'b1);
    resolve(6'd40, 1'b0);
    resolve(6'd8, 1'b1);
    idle(2);
    exp_cmt(6'd50);
    exp_cmt(6'd51);
    resolve(6'd50, 1'b0);
    idle(3);
    chk("ovf_sticky", ovf, 1);

    // Reset asserted while flushing
    alloc(4'b0001, 6'd60);
    exp_mis(6'd60);
    resolve(6'd60, 1'b1);
    step();
    step();
    chk("full_in_flush", full, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmt", cmt_brch, 0);
    chk("mid_rst_mis", mis_pred, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_full", full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    alloc(4'b0001, 6'd7);
    exp_cmt(6'd7);
    resolve(6'd7, 1'b0);
    idle(3);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
